// File: rtl/game_stats_pkg.sv
// Shared game definitions: FSM state encoding and default parameter values.
package game_stats_pkg;

    typedef enum logic [1:0] {
        ST_PLAY    = 2'd0,
        ST_RESPAWN = 2'd1,
        ST_OVER    = 2'd2,
        ST_WIN     = 2'd3
    } game_state_t;

    localparam int DEF_CLK_HZ      = 100_000_000;
    localparam int DEF_LIVES_MAX   = 3;
    localparam int DEF_SCORE_W     = 14;
    localparam int DEF_SCORE_MAX   = 9999;
    localparam int DEF_TIME_W      = 9;
    localparam int DEF_TIME_START  = 300;
    localparam int DEF_COIN_PTS    = 10;
    localparam int DEF_BONUS_PTS   = 5;
    localparam int DEF_TALLY_DIV   = 1_000_000;
    localparam int DEF_RESPAWN_CYC = 50_000_000;

endpackage

// File: rtl/game_stats_tick_gen.sv
// Divider counting 0..DIV-1 while enabled; tick is high on the last count of each period.
module tick_gen
    import game_stats_pkg::*;
#(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/game_stats.sv
// Score, game-time and lives bookkeeping for one player, driven by level event inputs.
//   state      | meaning
//   ST_PLAY    | game running: coins score, 1 s ticks count g_time down
//   ST_RESPAWN | life lost, respawn held high for RESPAWN_CYC cycles
//   ST_OVER    | no lives left, everything frozen
//   ST_WIN     | goal reached, remaining seconds tallied into score
module game_stats
    import game_stats_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int LIVES_MAX   = DEF_LIVES_MAX,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int SCORE_MAX   = DEF_SCORE_MAX,
    parameter int TIME_W      = DEF_TIME_W,
    parameter int TIME_START  = DEF_TIME_START,
    parameter int COIN_PTS    = DEF_COIN_PTS,
    parameter int BONUS_PTS   = DEF_BONUS_PTS,
    parameter int TALLY_DIV   = DEF_TALLY_DIV,
    parameter int RESPAWN_CYC = DEF_RESPAWN_CYC
) (
    input  logic                               clk,
    input  logic                               main_rst,
    input  logic                               coin_det,
    input  logic                               outbounds,
    input  logic                               game_win,
    input  logic                               restart,
    output logic [SCORE_W-1:0]                 score,
    output logic [TIME_W-1:0]                  g_time,
    output logic [$clog2(LIVES_MAX+1)-1:0]     lives,
    output logic [LIVES_MAX-1:0]               lives_led,
    output logic [1:0]                         state,
    output logic                               respawn
);

    localparam int LW = $clog2(LIVES_MAX + 1);

    game_state_t st_q, st_d;
    logic [SCORE_W-1:0]   score_d;
    logic [TIME_W-1:0]    g_time_d;
    logic [LW-1:0]        lives_d;
    logic [LIVES_MAX-1:0] lives_led_d;
    logic [SCORE_W:0]     coin_sum, bonus_sum;

    logic coin_q, out_q, win_q, restart_q;
    logic coin_edge, out_edge, win_edge, restart_edge;
    logic sec_tick, tally_tick, resp_tick, timeout;

    assign coin_edge    = coin_det  & ~coin_q;
    assign out_edge     = outbounds & ~out_q;
    assign win_edge     = game_win  & ~win_q;
    assign restart_edge = restart   & ~restart_q;

    tick_gen #(.DIV(CLK_HZ)) u_sec (
        .clk(clk), .rst_n(main_rst),
        .clr(st_q != ST_PLAY || restart_edge),
        .en(st_q == ST_PLAY),
        .tick(sec_tick)
    );

    // Tally stops counting once g_time is exhausted so WIN holds cleanly.
    tick_gen #(.DIV(TALLY_DIV)) u_tally (
        .clk(clk), .rst_n(main_rst),
        .clr(st_q != ST_WIN || restart_edge),
        .en(st_q == ST_WIN && g_time != '0),
        .tick(tally_tick)
    );

    tick_gen #(.DIV(RESPAWN_CYC)) u_resp (
        .clk(clk), .rst_n(main_rst),
        .clr(st_q != ST_RESPAWN || restart_edge),
        .en(st_q == ST_RESPAWN),
        .tick(resp_tick)
    );

    assign coin_sum  = {1'b0, score} + (SCORE_W+1)'(COIN_PTS);
    assign bonus_sum = {1'b0, score} + (SCORE_W+1)'(BONUS_PTS);
    assign timeout   = sec_tick && (g_time == TIME_W'(1));

    always_comb begin
        st_d     = st_q;
        score_d  = score;
        g_time_d = g_time;
        lives_d  = lives;
        case (st_q)
            ST_PLAY: begin
                if (coin_edge)
                    score_d = (coin_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                                   : coin_sum[SCORE_W-1:0];
                if (sec_tick && g_time != '0)
                    g_time_d = g_time - TIME_W'(1);
                if (win_edge) begin
                    st_d = ST_WIN;
                end else if (out_edge || timeout) begin
                    if (lives > LW'(1)) begin
                        lives_d = lives - LW'(1);
                        st_d    = ST_RESPAWN;
                    end else begin
                        lives_d = '0;
                        st_d    = ST_OVER;
                    end
                end
            end
            ST_RESPAWN: begin
                if (resp_tick) begin
                    st_d     = ST_PLAY;
                    g_time_d = TIME_W'(TIME_START);
                end
            end
            ST_WIN: begin
                if (tally_tick) begin
                    score_d  = (bonus_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                                     : bonus_sum[SCORE_W-1:0];
                    g_time_d = g_time - TIME_W'(1);
                end
            end
            default: ;
        endcase
        if (restart_edge) begin
            st_d     = ST_PLAY;
            score_d  = '0;
            g_time_d = TIME_W'(TIME_START);
            lives_d  = LW'(LIVES_MAX);
        end
    end

    always_comb begin
        lives_led_d = '0;
        for (int i = 0; i < LIVES_MAX; i++)
            lives_led_d[i] = (int'(lives_d) > i);
    end

    always_ff @(posedge clk or negedge main_rst) begin
        if (!main_rst) begin
            st_q      <= ST_PLAY;
            score     <= '0;
            g_time    <= TIME_W'(TIME_START);
            lives     <= LW'(LIVES_MAX);
            lives_led <= '1;
            respawn   <= 1'b0;
            coin_q    <= 1'b0;
            out_q     <= 1'b0;
            win_q     <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            score     <= score_d;
            g_time    <= g_time_d;
            lives     <= lives_d;
            lives_led <= lives_led_d;
            respawn   <= (st_d == ST_RESPAWN);
            coin_q    <= coin_det;
            out_q     <= outbounds;
            win_q     <= game_win;
            restart_q <= restart;
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_game_stats.sv
// Bench for game_stats: directed scenarios plus random level stimulus against a behavioural model.
module tb_game_stats;

    localparam int CLK_HZ = 10, LIVES_MAX = 3, SCORE_MAX = 25, TIME_START = 5;
    localparam int COIN_PTS = 10, BONUS_PTS = 5, TALLY_DIV = 2, RESPAWN_CYC = 4;
    localparam int M_PLAY = 0, M_RESPAWN = 1, M_OVER = 2, M_WIN = 3;

    logic        clk = 1'b0;
    logic        main_rst, coin_det, outbounds, game_win, restart;
    logic [13:0] score;
    logic [8:0]  g_time;
    logic [1:0]  lives;
    logic [2:0]  lives_led;
    logic [1:0]  state;
    logic        respawn;

    game_stats #(
        .CLK_HZ(CLK_HZ), .LIVES_MAX(LIVES_MAX), .SCORE_W(14), .SCORE_MAX(SCORE_MAX),
        .TIME_W(9), .TIME_START(TIME_START), .COIN_PTS(COIN_PTS), .BONUS_PTS(BONUS_PTS),
        .TALLY_DIV(TALLY_DIV), .RESPAWN_CYC(RESPAWN_CYC)
    ) dut (
        .clk(clk), .main_rst(main_rst), .coin_det(coin_det), .outbounds(outbounds),
        .game_win(game_win), .restart(restart), .score(score), .g_time(g_time),
        .lives(lives), .lives_led(lives_led), .state(state), .respawn(respawn)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model: elapsed-cycle bookkeeping per game phase.
    int m_score, m_time, m_lives, m_state;
    int play_cyc, resp_cyc, tally_cyc;
    bit p_coin, p_out, p_win, p_rst;

    function automatic int sat(input int v);
        return (v > SCORE_MAX) ? SCORE_MAX : v;
    endfunction

    task automatic model_init();
        m_score = 0; m_time = TIME_START; m_lives = LIVES_MAX; m_state = M_PLAY;
        play_cyc = 0; resp_cyc = 0; tally_cyc = 0;
    endtask

    task automatic model_step(input bit c, input bit o, input bit w, input bit r);
        bit ce, oe, we, re, lose;
        ce = c && !p_coin; oe = o && !p_out; we = w && !p_win; re = r && !p_rst;
        p_coin = c; p_out = o; p_win = w; p_rst = r;
        if (re) begin
            model_init();
            return;
        end
        case (m_state)
            M_PLAY: begin
                play_cyc++;
                lose = oe;
                if (ce) m_score = sat(m_score + COIN_PTS);
                if (play_cyc % CLK_HZ == 0 && m_time > 0) begin
                    m_time--;
                    if (m_time == 0) lose = 1'b1;
                end
                if (we) begin
                    m_state = M_WIN; tally_cyc = 0;
                end else if (lose) begin
                    if (m_lives > 1) begin m_lives--; m_state = M_RESPAWN; resp_cyc = 0; end
                    else begin m_lives = 0; m_state = M_OVER; end
                end
            end
            M_RESPAWN: begin
                resp_cyc++;
                if (resp_cyc == RESPAWN_CYC) begin
                    m_state = M_PLAY; m_time = TIME_START; play_cyc = 0;
                end
            end
            M_WIN: begin
                if (m_time > 0) begin
                    tally_cyc++;
                    if (tally_cyc % TALLY_DIV == 0) begin
                        m_score = sat(m_score + BONUS_PTS);
                        m_time--;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        int led;
        led = 0;
        for (int i = 0; i < LIVES_MAX; i++) if (m_lives > i) led |= (1 << i);
        check("score",     int'(score),     m_score);
        check("g_time",    int'(g_time),    m_time);
        check("lives",     int'(lives),     m_lives);
        check("lives_led", int'(lives_led), led);
        check("state",     int'(state),     m_state);
        check("respawn",   int'(respawn),   (m_state == M_RESPAWN) ? 1 : 0);
    endtask

    task automatic cycle(input bit c, input bit o, input bit w, input bit r);
        coin_det = c; outbounds = o; game_win = w; restart = r;
        @(posedge clk);
        model_step(c, o, w, r);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_score"},  int'(score),     0);
        check({tag, "_gtime"},  int'(g_time),    TIME_START);
        check({tag, "_lives"},  int'(lives),     LIVES_MAX);
        check({tag, "_led"},    int'(lives_led), 7);
        check({tag, "_state"},  int'(state),     M_PLAY);
        check({tag, "_resp"},   int'(respawn),   0);
    endtask

    // Asserted between edges to exercise the asynchronous path.
    task automatic hw_reset();
        #2;
        coin_det = 0; outbounds = 0; game_win = 0; restart = 0;
        main_rst = 1'b0;
        #1;
        model_init();
        p_coin = 0; p_out = 0; p_win = 0; p_rst = 0;
        check_all();
        @(negedge clk);
        main_rst = 1'b1;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit c, o, w, r;
        int guard;
        main_rst = 1'b0; coin_det = 0; outbounds = 0; game_win = 0; restart = 0;
        model_init();
        p_coin = 0; p_out = 0; p_win = 0; p_rst = 0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        main_rst = 1'b1;

        // held coin counts once, then saturation on the third coin
        repeat (20) cycle(1, 0, 0, 0);
        check("held_coin", int'(score), 10);
        cycle(0, 0, 0, 0); cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(1, 0, 0, 0);
        check("sat_score", int'(score), 25);

        // timeout path
        hw_reset();
        repeat (10) cycle(0, 0, 0, 0);
        check("first_tick", int'(g_time), 4);
        repeat (40) cycle(0, 0, 0, 0);
        check("to_state", int'(state), M_RESPAWN);
        check("to_lives", int'(lives), 2);
        check("to_gtime", int'(g_time), 0);
        check("to_resp",  int'(respawn), 1);
        repeat (3) cycle(0, 0, 0, 0);
        check("resp_len", int'(respawn), 1);
        cycle(0, 0, 0, 0);
        check("resp_end", int'(state), M_PLAY);
        check("reload",   int'(g_time), TIME_START);

        // three lives lost
        hw_reset();
        cycle(0, 1, 0, 0);
        check("led_2", int'(lives_led), 3);
        repeat (4) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        check("led_1", int'(lives_led), 1);
        repeat (4) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        check("led_0", int'(lives_led), 0);
        check("over",  int'(state), M_OVER);
        repeat (5) cycle(1, 0, 0, 0);
        check("over_frozen", int'(score), 0);

        // win tally from g_time 3 with score 10
        hw_reset();
        cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
        guard = 0;
        while (m_time != 3 && guard < 40) begin cycle(0, 0, 0, 0); guard++; end
        check("wait_gtime3", (guard < 40) ? 1 : 0, 1);
        cycle(0, 0, 1, 0);
        check("win_state", int'(state), M_WIN);
        cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        check("tally_1", int'(score), 15);
        repeat (4) cycle(0, 0, 0, 0);
        check("tally_end", int'(score), 25);
        check("tally_gt0", int'(g_time), 0);
        repeat (4) cycle(0, 0, 0, 0);
        check("win_hold", int'(score), 25);

        // same-cycle events
        hw_reset();
        cycle(1, 1, 0, 0);
        check("co_score", int'(score), 10);
        check("co_lives", int'(lives), 2);
        check("co_state", int'(state), M_RESPAWN);
        repeat (4) cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 0);
        check("wo_state", int'(state), M_WIN);
        check("wo_lives", int'(lives), 2);

        // restart mid-respawn
        hw_reset();
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0); cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        check_reset_vals("restart");
        cycle(0, 0, 0, 0);

        // reset mid-tally
        cycle(1, 0, 0, 0); cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        hw_reset();
        check_reset_vals("rst_tally");
        repeat (3) cycle(0, 0, 0, 0);
        check("no_residual", int'(score), 0);

        // random levels
        c = 0; o = 0; w = 0; r = 0;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                hw_reset();
                c = 0; o = 0; w = 0; r = 0;
            end
            if ($urandom_range(0, 99) < 25) c = !c;
            if ($urandom_range(0, 99) < 6)  o = !o;
            if ($urandom_range(0, 99) < 2)  w = !w;
            if ($urandom_range(0, 99) < 2)  r = !r;
            cycle(c, o, w, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_stats.md
GAME_STATS -- requirements
Module: game_stats

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, clk cycles per 1 s game tick.
REQ-002 SHALL have parameter LIVES_MAX, default 3, starting and maximum lives (1..15).
REQ-003 SHALL have parameter SCORE_W, default 14, score width.
REQ-004 SHALL have parameter SCORE_MAX, default 9999, score saturation value (< 2**SCORE_W).
REQ-005 SHALL have parameter TIME_W, default 9, game-time width.
REQ-006 SHALL have parameter TIME_START, default 300, seconds loaded at start, restart and respawn.
REQ-007 SHALL have parameter COIN_PTS, default 10, points per coin.
REQ-008 SHALL have parameter BONUS_PTS, default 5, points per remaining second at win.
REQ-009 SHALL have parameter TALLY_DIV, default 1000000, clk cycles per bonus-tally step.
REQ-010 SHALL have parameter RESPAWN_CYC, default 50000000, respawn hold length in cycles.
REQ-011 SHALL have the ports: clk input 1, the single clock; main_rst input 1, asynchronous active-low reset.
REQ-012 SHALL have the ports: coin_det input 1, level, coin overlap flag; outbounds input 1, level, player out of bounds; game_win input 1, level, goal reached; restart input 1, level, new-game request.
REQ-013 SHALL have the ports: score output SCORE_W; g_time output TIME_W; lives output clog2(LIVES_MAX+1); lives_led output LIVES_MAX, thermometer; state output 2 (0 PLAY, 1 RESPAWN, 2 OVER, 3 WIN); respawn output 1, high while respawning.

Function
REQ-014 SHALL register coin_det, outbounds, game_win and restart, and act only on rising edges; a held level SHALL count once.
REQ-015 SHALL implement FSM PLAY, RESPAWN, OVER, WIN; every output registered, 1-cycle latency from the detected edge.
REQ-016 In PLAY, a coin edge SHALL add COIN_PTS to score, saturating at SCORE_MAX.
REQ-017 In PLAY, a 1 s tick (free counter 0..CLK_HZ-1, cleared on entering PLAY) SHALL decrement g_time; reaching 0 SHALL act as an outbounds edge.
REQ-018 In PLAY, an outbounds edge with lives>1 SHALL decrement lives and go to RESPAWN; with lives==1, set lives=0 and go to OVER.
REQ-019 RESPAWN SHALL hold respawn=1 for exactly RESPAWN_CYC cycles, then load g_time=TIME_START and return to PLAY; coin, outbounds and win edges SHALL be ignored there.
REQ-020 In PLAY, a game_win edge SHALL go to WIN; WIN SHALL every TALLY_DIV cycles add BONUS_PTS (saturating) and decrement g_time until g_time==0, then hold.
REQ-021 OVER and WIN SHALL be terminal: score, g_time and lives frozen except the WIN tally.
REQ-022 Same-cycle coin and outbounds edges SHALL credit the coin and then apply the life loss.
REQ-023 A same-cycle game_win edge SHALL take priority over outbounds and timeout; the coin is still credited.
REQ-024 A restart edge in any state SHALL reinitialise exactly to reset values on the next cycle and override all other events.
REQ-025 lives_led[i] SHALL equal (lives > i).

Reset
REQ-026 main_rst low SHALL asynchronously set state=PLAY, score=0, g_time=TIME_START, lives=LIVES_MAX, lives_led all ones, respawn=0, all counters and edge registers 0.
REQ-027 Reset mid-RESPAWN or mid-tally SHALL abort it with no residual credit.

Structure
REQ-028 State encodings and default parameter values SHALL live in the shared game package.
REQ-029 One sub-module, tick_gen (parametrised divider with clear and a 1-cycle tick output), SHALL be instantiated for the 1 s, tally and respawn counters.

Verification (CLK_HZ=10, TALLY_DIV=2, RESPAWN_CYC=4, TIME_START=5, LIVES_MAX=3, SCORE_MAX=25)
REQ-030 coin_det held high 20 cycles, then 2 more pulses -> score 30? no: saturates at 25 after the third coin; held level counts once.
REQ-031 Idle in PLAY 50 cycles -> g_time 5..0 at 10-cycle steps; timeout -> lives 2, respawn high 4 cycles, g_time reloads to 5.
REQ-032 Three outbounds edges, each after respawn ends -> lives 2,1,0; state OVER; lives_led 011,001,000.
REQ-033 game_win edge at g_time=3 with score 10 -> WIN; score 15,20,25 at 2-cycle steps; g_time 0; holds.
REQ-034 Same-cycle coin+outbounds -> score+10, lives-1, RESPAWN; same-cycle win+outbounds -> WIN, lives unchanged.
REQ-035 restart edge mid-RESPAWN and main_rst low mid-tally -> all outputs at reset values next cycle.
